// File: rtl/mem_if_pkg.sv
// Shared load/store memory interface types.
// Used by the LSQ and the memory-side responder.
package mem_if_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int IDX_W  = ADDR_W - 2;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic              rw;
      logic [ID_W-1:0]   id;
   } mem_req_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } svc_state_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO between the LSQ port and the service FSM.
// Head is visible combinationally; full blocks push even on pop.
module req_fifo
   import mem_if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  mem_req_t                   din,
   output mem_req_t                   dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   mem_req_t         buf_q [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign dout    = buf_q[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Entry storage, written at the tail.
   always_ff @(posedge clk) begin
      if (do_push)
         buf_q[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: buffers tagged requests and services
// them in order with word-index dependent latency.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int WORDS    = 1024,
   parameter int FAST_LAT = 1,
   parameter int SLOW_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rw_in,
   input  logic [ID_W-1:0]   id_in,
   input  logic              valid_in,
   output logic [DATA_W-1:0] data_out,
   output logic [ID_W-1:0]   id_out,
   output logic              ready_out,
   output logic              stall_out
);

   localparam int AW      = $clog2(WORDS);
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int LAT_MAX = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
   localparam int LW      = $clog2(LAT_MAX) + 1;
   localparam logic [LW-1:0] FAST_M1 = LW'(FAST_LAT - 1);
   localparam logic [LW-1:0] SLOW_M1 = LW'(SLOW_LAT - 1);

   mem_req_t          req_in;
   mem_req_t          head;
   logic              push;
   logic              pop;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;

   svc_state_t        state_q, state_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   mem_req_t          svc_q, svc_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              rdy_q, rdy_d;
   logic              wr_en;

   logic [DATA_W-1:0] mem [WORDS];
   logic [AW-1:0]     widx;
   logic [DATA_W-1:0] rd_word;
   logic              unused_bits;

   assign req_in.idx  = IDX_W'(addr_in[2 +: AW]);
   assign req_in.data = data_in;
   assign req_in.rw   = rw_in;
   assign req_in.id   = id_in;
   assign push        = valid_in && !fifo_full;

   assign widx    = svc_q.idx[AW-1:0];
   assign rd_word = mem[widx];

   assign unused_bits = ^{addr_in[1:0], addr_in[ADDR_W-1:2+AW],
                          svc_q.idx[IDX_W-1:AW], fifo_cnt};

   req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (req_in),
      .dout  (head),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Service FSM: fetch head, count down latency, then complete.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      svc_d   = svc_q;
      dout_d  = dout_q;
      id_d    = id_q;
      rdy_d   = 1'b0;
      pop     = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               svc_d   = head;
               cnt_d   = head.idx[0] ? SLOW_M1 : FAST_M1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               wr_en   = svc_q.rw;
               dout_d  = svc_q.rw ? '0 : rd_word;
               id_d    = svc_q.id;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, service and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         svc_q   <= '0;
         dout_q  <= '0;
         id_q    <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         svc_q   <= svc_d;
         dout_q  <= dout_d;
         id_q    <= id_d;
         rdy_q   <= rdy_d;
      end
   end

   // Data array; never cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[widx] <= svc_q.data;
   end

   assign data_out  = dout_q;
   assign id_out    = id_q;
   assign ready_out = rdy_q;
   assign stall_out = fifo_full;

endmodule
